// File: rtl/mem_stage.sv
// Memory-access stage: serialises loads/stores over the byte-wide
// memory-controller port and registers results towards writeback.
package mem_pkg;
  localparam int CMD_NOP = 0;
  localparam int CMD_ALU = 1;
  localparam int CMD_LB  = 8;
  localparam int CMD_LH  = 9;
  localparam int CMD_LW  = 10;
  localparam int CMD_LBU = 11;
  localparam int CMD_LHU = 12;
  localparam int CMD_SB  = 13;
  localparam int CMD_SH  = 14;
  localparam int CMD_SW  = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;
endpackage

module mem_stage
  import mem_pkg::*;
#(
  parameter int CMD_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [CMD_W-1:0] cmdtype_in,
  input  logic [4:0]       rsd_addr_in,
  input  logic [31:0]      rsd_data_in,
  input  logic             write_rsd_in,
  input  logic [31:0]      mem_addr_in,
  input  logic [31:0]      store_data_in,
  output logic             mem_req_o,
  input  logic             mem_grant_i,
  output logic [31:0]      mem_a_o,
  output logic             mem_wr_o,
  output logic [7:0]       mem_dout_o,
  input  logic [7:0]       mem_din_i,
  output logic             stall_o,
  output logic [4:0]       rsd_addr_o,
  output logic [31:0]      rsd_data_o,
  output logic             write_rsd_o,
  output logic             mem_forward_o,
  output logic [4:0]       mem_forward_addr_o,
  output logic [31:0]      mem_forward_data_o
);

  logic is_lb, is_lh, is_lw, is_lbu, is_lhu;
  logic is_sb, is_sh, is_sw;
  logic is_ld, is_st, is_mem;
  logic [2:0] n_in;

  assign is_lb  = cmdtype_in == CMD_W'(CMD_LB);
  assign is_lh  = cmdtype_in == CMD_W'(CMD_LH);
  assign is_lw  = cmdtype_in == CMD_W'(CMD_LW);
  assign is_lbu = cmdtype_in == CMD_W'(CMD_LBU);
  assign is_lhu = cmdtype_in == CMD_W'(CMD_LHU);
  assign is_sb  = cmdtype_in == CMD_W'(CMD_SB);
  assign is_sh  = cmdtype_in == CMD_W'(CMD_SH);
  assign is_sw  = cmdtype_in == CMD_W'(CMD_SW);

  assign is_ld  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
  assign is_st  = is_sb | is_sh | is_sw;
  assign is_mem = is_ld | is_st;

  always_comb begin
    n_in = 3'd0;
    unique case (1'b1)
      is_lb, is_lbu, is_sb: n_in = 3'd1;
      is_lh, is_lhu, is_sh: n_in = 3'd2;
      is_lw, is_sw:         n_in = 3'd4;
      default:              n_in = 3'd0;
    endcase
  end

  state_t      state, nstate;
  logic        lat_st;
  logic        lat_sx;
  logic [2:0]  lat_n;
  logic [31:0] base;
  logic [31:0] sdata;
  logic [4:0]  lat_rd;
  logic [2:0]  idx;
  logic        cap_vld;
  logic [1:0]  cap_idx;
  logic [31:0] lbuf;

  logic        in_xfer, more, issue, last;
  logic        st_done, ld_done;
  logic [31:0] asm_w, ld_val;
  logic [4:0]  nxt_addr;
  logic [31:0] nxt_data;
  logic        nxt_we;

  assign in_xfer = state == S_XFER;
  assign more    = idx < lat_n;
  assign issue   = in_xfer & more & mem_grant_i & rdy_in;
  assign last    = idx == lat_n - 3'd1;
  assign st_done = issue & lat_st & last;
  assign ld_done = in_xfer & ~lat_st & cap_vld
                 & ({1'b0, cap_idx} == lat_n - 3'd1);

  // Merge the byte arriving this cycle so the final one lands directly
  always_comb begin
    asm_w = lbuf;
    asm_w[{cap_idx, 3'b000} +: 8] = mem_din_i;
  end

  always_comb begin
    ld_val = asm_w;
    case (lat_n)
      3'd1: ld_val = {{24{lat_sx & asm_w[7]}}, asm_w[7:0]};
      3'd2: ld_val = {{16{lat_sx & asm_w[15]}}, asm_w[15:0]};
      default: ld_val = asm_w;
    endcase
  end

  assign mem_req_o  = (state == S_REQ) | (in_xfer & more);
  assign mem_wr_o   = issue & lat_st;
  assign mem_a_o    = in_xfer ? base + {29'd0, idx} : '0;
  assign mem_dout_o = (in_xfer & lat_st)
                    ? sdata[{idx[1:0], 3'b000} +: 8] : '0;

  assign stall_o = rst_in
                 & ((state == S_IDLE & is_mem)
                 | state == S_REQ | in_xfer);

  always_comb begin
    nstate   = state;
    nxt_addr = '0;
    nxt_data = '0;
    nxt_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_mem) begin
          nstate = S_REQ;
        end else begin
          nxt_addr = rsd_addr_in;
          nxt_data = rsd_data_in;
          nxt_we   = write_rsd_in & (|rsd_addr_in);
        end
      end
      S_REQ: begin
        if (mem_grant_i) nstate = S_XFER;
      end
      S_XFER: begin
        if (st_done) begin
          nstate = S_DONE;
        end else if (ld_done) begin
          nstate   = S_DONE;
          nxt_addr = lat_rd;
          nxt_data = ld_val;
          nxt_we   = |lat_rd;
        end
      end
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      lat_st      <= 1'b0;
      lat_sx      <= 1'b0;
      lat_n       <= '0;
      base        <= '0;
      sdata       <= '0;
      lat_rd      <= '0;
      idx         <= '0;
      cap_vld     <= 1'b0;
      cap_idx     <= '0;
      lbuf        <= '0;
      rsd_addr_o  <= '0;
      rsd_data_o  <= '0;
      write_rsd_o <= 1'b0;
    end else if (rdy_in) begin
      state       <= nstate;
      rsd_addr_o  <= nxt_addr;
      rsd_data_o  <= nxt_data;
      write_rsd_o <= nxt_we;
      cap_vld     <= issue & ~lat_st;
      cap_idx     <= idx[1:0];
      if (cap_vld) lbuf <= asm_w;
      if (state == S_IDLE && is_mem) begin
        lat_st <= is_st;
        lat_sx <= is_lb | is_lh;
        lat_n  <= n_in;
        base   <= mem_addr_in;
        sdata  <= store_data_in;
        lat_rd <= rsd_addr_in;
        idx    <= '0;
        lbuf   <= '0;
      end else if (issue) begin
        idx <= idx + 3'd1;
      end
    end
  end

  assign mem_forward_o      = write_rsd_o & (|rsd_addr_o);
  assign mem_forward_addr_o = rsd_addr_o;
  assign mem_forward_data_o = rsd_data_o;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream against a
// byte-addressed reference memory plus directed latency/reset cases.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  cmdtype_in;
  logic [4:0]  rsd_addr_in;
  logic [31:0] rsd_data_in;
  logic        write_rsd_in;
  logic [31:0] mem_addr_in;
  logic [31:0] store_data_in;
  logic        mem_req_o;
  logic        mem_grant_i;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i;
  logic        stall_o;
  logic [4:0]  rsd_addr_o;
  logic [31:0] rsd_data_o;
  logic        write_rsd_o;
  logic        mem_forward_o;
  logic [4:0]  mem_forward_addr_o;
  logic [31:0] mem_forward_data_o;

  mem_stage #(.CMD_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cmdtype_in(cmdtype_in), .rsd_addr_in(rsd_addr_in),
    .rsd_data_in(rsd_data_in), .write_rsd_in(write_rsd_in),
    .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
    .mem_req_o(mem_req_o), .mem_grant_i(mem_grant_i),
    .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
    .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i),
    .stall_o(stall_o), .rsd_addr_o(rsd_addr_o),
    .rsd_data_o(rsd_data_o), .write_rsd_o(write_rsd_o),
    .mem_forward_o(mem_forward_o),
    .mem_forward_addr_o(mem_forward_addr_o),
    .mem_forward_data_o(mem_forward_data_o)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  wb_t         exp_q[$];
  wr_t         wq[$];
  logic [31:0] rd_log[$];
  logic [7:0]  ram[logic [31:0]];
  logic [7:0]  ref_mem[logic [31:0]];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  logic [31:0] last_data = '0;
  logic [31:0] rdy_pat = '1;
  logic [31:0] gnt_pat = '1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3c;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_b(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
  endfunction

  function automatic int nbytes(input int c);
    case (c)
      CMD_LB, CMD_LBU, CMD_SB: return 1;
      CMD_LH, CMD_LHU, CMD_SH: return 2;
      CMD_LW, CMD_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_load(input int c);
    return c == CMD_LB || c == CMD_LH || c == CMD_LW
        || c == CMD_LBU || c == CMD_LHU;
  endfunction

  function automatic bit is_store(input int c);
    return c == CMD_SB || c == CMD_SH || c == CMD_SW;
  endfunction

  // Reference: value = sum of bytes * 256^i, signed ops re-centred
  task automatic model(input int cmd, input logic [4:0] rd,
                       input logic [31:0] data, input logic we,
                       input logic [31:0] addr, input logic [31:0] sd);
    int     n;
    longint v;
    wb_t    e;
    wr_t    w;
    n = nbytes(cmd);
    if (is_load(cmd)) begin
      v = 0;
      for (int i = 0; i < n; i++)
        v += longint'(ref_rd(addr + 32'(i))) << (8 * i);
      if ((cmd == CMD_LB || cmd == CMD_LH)
          && v >= (longint'(1) << (8 * n - 1)))
        v -= longint'(1) << (8 * n);
      if (rd != 0) begin
        e.rd = rd;
        e.data = v[31:0];
        exp_q.push_back(e);
      end
    end else if (is_store(cmd)) begin
      for (int i = 0; i < n; i++) begin
        w.a = addr + 32'(i);
        w.d = 8'((sd >> (8 * i)) & 32'hff);
        ref_mem[w.a] = w.d;
        wq.push_back(w);
      end
    end else if (we && rd != 0) begin
      e.rd = rd;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input int cmd, input logic [4:0] rd,
                       input logic [31:0] data, input logic we,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input bit rnd, output int busy,
                       output logic st0);
    bit adv;
    bit done;
    model(cmd, rd, data, we, addr, sd);
    cmdtype_in    = 6'(cmd);
    rsd_addr_in   = rd;
    rsd_data_in   = data;
    write_rsd_in  = we;
    mem_addr_in   = addr;
    store_data_in = sd;
    busy = 0;
    st0  = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (rnd) begin
        rdy_in      = $urandom_range(0, 3) != 0;
        mem_grant_i = $urandom_range(0, 2) != 0;
      end else begin
        rdy_in      = (c < 32) ? rdy_pat[c[4:0]] : 1'b1;
        mem_grant_i = (c < 32) ? gnt_pat[c[4:0]] : 1'b1;
      end
      @(negedge clk_in);
      if (c == 0) st0 = stall_o;
      else if (stall_o) busy++;
      adv = rdy_in && !stall_o;
      @(posedge clk_in);
      #1;
      done = adv;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout: cmd %0d still stalled, want accept",
               cmd);
    end
  endtask

  // Byte-port memory: first granted request cycle is the handshake,
  // later granted cycles are issues; read data returns a cycle later.
  initial begin
    bit          gr;
    bit          rd_do;
    bit          wr_do;
    logic [31:0] a;
    logic [7:0]  d;
    wr_t         w;
    gr = 1'b0;
    mem_din_i = '0;
    forever begin
      @(negedge clk_in);
      rd_do = 1'b0;
      if (!rst_in || !mem_req_o) gr = 1'b0;
      else if (rdy_in && mem_grant_i) begin
        if (gr && !mem_wr_o) rd_do = 1'b1;
        gr = 1'b1;
      end
      wr_do = rst_in && mem_wr_o;
      a = mem_a_o;
      d = mem_dout_o;
      @(posedge clk_in);
      #1;
      if (rd_do) begin
        mem_din_i = ram_rd(a);
        rd_log.push_back(a);
      end
      if (wr_do) begin
        ram[a] = d;
        n_wr++;
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL extra_write: got %h@%h want no write", d, a);
        end else begin
          w = wq.pop_front();
          check("wr_addr", a, w.a);
          check("wr_data", {24'd0, d}, {24'd0, w.d});
        end
      end
    end
  end

  // Writeback monitor: one result consumed per rdy-high cycle
  initial begin
    wb_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in && rdy_in && write_rsd_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_wb: got x%0d=%h want no write",
                   rsd_addr_o, rsd_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", {27'd0, rsd_addr_o}, {27'd0, e.rd});
          check("wb_data", rsd_data_o, e.data);
          check("fwd_vld", {31'd0, mem_forward_o}, 32'd1);
          check("fwd_addr", {27'd0, mem_forward_addr_o}, {27'd0, e.rd});
          check("fwd_data", mem_forward_data_o, e.data);
          last_data = rsd_data_o;
        end
      end
    end
  end

  initial begin
    int   busy;
    logic st0;
    int   wr0;
    int   cmds[10];
    int   cm;
    logic [31:0] ad;
    cmds = '{CMD_ALU, CMD_NOP, CMD_LB, CMD_LH, CMD_LW,
             CMD_LBU, CMD_LHU, CMD_SB, CMD_SH, CMD_SW};

    rst_in = 1'b0;
    rdy_in = 1'b1;
    mem_grant_i = 1'b0;
    cmdtype_in = 6'(CMD_LW);
    rsd_addr_in = 5'd1;
    rsd_data_in = 32'hffff_ffff;
    write_rsd_in = 1'b1;
    mem_addr_in = '0;
    store_data_in = '0;
    ram[32'h1000] = 8'h78; ref_mem[32'h1000] = 8'h78;
    ram[32'h1001] = 8'h56; ref_mem[32'h1001] = 8'h56;
    ram[32'h1002] = 8'h34; ref_mem[32'h1002] = 8'h34;
    ram[32'h1003] = 8'h12; ref_mem[32'h1003] = 8'h12;
    ram[32'h0200] = 8'h80; ref_mem[32'h0200] = 8'h80;

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_we", {31'd0, write_rsd_o}, 32'd0);
    check("rst_data", rsd_data_o, 32'd0);
    check("rst_fwd", {31'd0, mem_forward_o}, 32'd0);
    cmdtype_in = 6'(CMD_NOP);
    write_rsd_in = 1'b0;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    issue(CMD_ALU, 5'd5, 32'h1234_5678, 1'b1, '0, '0, 1'b0, busy, st0);
    check("addi_stall0", {31'd0, st0}, 32'd0);
    check("addi_busy", busy, 0);
    check("addi_data", rsd_data_o, 32'h1234_5678);
    check("addi_rd", {27'd0, rsd_addr_o}, 32'd5);
    check("addi_fwd", {31'd0, mem_forward_o}, 32'd1);

    rd_log.delete();
    issue(CMD_LW, 5'd7, '0, 1'b1, 32'h1000, '0, 1'b0, busy, st0);
    check("lw_stall0", {31'd0, st0}, 32'd1);
    check("lw_busy", busy, 6);
    check("lw_nreads", rd_log.size(), 4);
    for (int k = 0; k < 4 && k < rd_log.size(); k++)
      check("lw_addr", rd_log[k], 32'h1000 + 32'(k));
    check("lw_data", last_data, 32'h1234_5678);

    issue(CMD_LB, 5'd3, '0, 1'b1, 32'h200, '0, 1'b0, busy, st0);
    check("lb_data", last_data, 32'hffff_ff80);
    issue(CMD_LBU, 5'd4, '0, 1'b1, 32'h200, '0, 1'b0, busy, st0);
    check("lbu_data", last_data, 32'h0000_0080);

    wr0 = n_wr;
    issue(CMD_SH, 5'd9, '0, 1'b1, 32'h3, 32'haabb_ccdd, 1'b0,
          busy, st0);
    check("sh_nwr", n_wr - wr0, 2);
    check("sh_busy", busy, 3);

    rdy_pat = '1;
    rdy_pat[7] = 1'b0;
    gnt_pat = '1;
    gnt_pat[4] = 1'b0;
    gnt_pat[5] = 1'b0;
    issue(CMD_LW, 5'd8, '0, 1'b1, 32'h1000, '0, 1'b0, busy, st0);
    check("lw_slow_busy", busy, 9);
    check("lw_slow_data", last_data, 32'h1234_5678);
    rdy_pat = '1;
    gnt_pat = '1;

    cmdtype_in = 6'(CMD_LW);
    rsd_addr_in = 5'd6;
    mem_addr_in = 32'h40;
    rdy_in = 1'b1;
    mem_grant_i = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    check("mid_rst_a", mem_a_o, 32'd0);
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_we", {31'd0, write_rsd_o}, 32'd0);
    check("mid_rst_fwd", {31'd0, mem_forward_o}, 32'd0);
    @(posedge clk_in);
    #1;
    cmdtype_in = 6'(CMD_NOP);
    rst_in = 1'b1;
    issue(CMD_ALU, 5'd10, 32'hcafe_0001, 1'b1, '0, '0, 1'b0,
          busy, st0);
    check("post_rst_addi", rsd_data_o, 32'hcafe_0001);

    for (int t = 0; t < 200; t++) begin
      cm = cmds[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0)
        ad = 32'hffff_fffc + 32'($urandom_range(0, 3));
      else
        ad = 32'h100 + 32'($urandom_range(0, 63));
      issue(cm, 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), ad, $urandom, 1'b1, busy, st0);
    end

    rdy_in = 1'b1;
    mem_grant_i = 1'b1;
    issue(CMD_NOP, 5'd0, '0, 1'b0, '0, '0, 1'b0, busy, st0);
    repeat (3) @(posedge clk_in);
    #1;
    check("wb_drained", exp_q.size(), 0);
    check("wr_drained", wq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
